// File: rtl/a2bus_host.sv
// Apple II style bus host: turns a one-deep command register into 7M-phased
// bus cycles with registered PHI, select and data-enable outputs.
module a2bus_host #(
    parameter logic [2:0] SLOT   = 3'd7,
    parameter int         LONGEN = 1
) (
    input  logic        C7M,
    input  logic        RES,
    input  logic        REQ,
    output logic        RDY,
    input  logic [15:0] REQA,
    input  logic        REQW,
    input  logic [7:0]  REQD,
    output logic        DONE,
    output logic [7:0]  RDATA,
    output logic        PHI0,
    output logic        PHI1,
    output logic [15:0] A,
    output logic        nWE,
    output logic [7:0]  Dout,
    output logic        DOE,
    input  logic [7:0]  Din,
    output logic        nDEVSEL,
    output logic        nIOSEL,
    output logic        nIOSTRB
);

    logic [2:0]  p;
    logic [6:0]  cyc;

    // held (accepted, not yet launched) command
    logic        hv;
    logic [15:0] ha;
    logic        hw;
    logic [7:0]  hd;

    // command occupying the current bus cycle
    logic        cv;
    logic        cw;
    logic [7:0]  cd;

    logic [2:0]  last;
    logic [2:0]  p_nxt;
    logic        wrap;
    logic        accept;
    logic        dev_hit;
    logic        io_hit;
    logic        strb_hit;
    logic        drive;

    assign RDY = ~hv;

    always_comb begin
        last     = ((LONGEN != 0) && (cyc == 7'd64)) ? 3'd7 : 3'd6;
        wrap     = (p == last);
        p_nxt    = wrap ? 3'd0 : p + 3'd1;
        accept   = REQ && !hv;
        dev_hit  = cv && (A[15:4] == (12'hC08 + {9'd0, SLOT}));
        io_hit   = cv && (A[15:8] == {5'b11000, SLOT});
        strb_hit = cv && (A[15:11] == 5'b11001);
        drive    = cv && cw && (p_nxt >= 3'd4);
    end

    // Selects and PHI are computed from the next phase so the registered
    // outputs line up with the phase counter itself.
    always_ff @(posedge C7M) begin
        if (RES) begin
            p       <= '0;
            cyc     <= '0;
            hv      <= 1'b0;
            ha      <= '0;
            hw      <= 1'b0;
            hd      <= '0;
            cv      <= 1'b0;
            cw      <= 1'b0;
            cd      <= '0;
            PHI1    <= 1'b1;
            PHI0    <= 1'b0;
            A       <= '0;
            nWE     <= 1'b1;
            nDEVSEL <= 1'b1;
            nIOSEL  <= 1'b1;
            nIOSTRB <= 1'b1;
            DOE     <= 1'b0;
            Dout    <= '0;
            DONE    <= 1'b0;
            RDATA   <= '0;
        end else begin
            p    <= p_nxt;
            DONE <= 1'b0;
            if (wrap) begin
                cyc  <= (cyc == 7'd64) ? 7'd0 : cyc + 7'd1;
                DONE <= cv;
                if (cv && !cw) begin
                    RDATA <= Din;
                end
                cv  <= hv;
                cw  <= hv && hw;
                cd  <= hv ? hd : 8'h00;
                A   <= hv ? ha : 16'h0000;
                nWE <= !(hv && hw);
                hv  <= 1'b0;
            end
            // Launch sees the register as it was before this edge, so a
            // command accepted on the P0-entry edge waits a full bus cycle.
            if (accept) begin
                hv <= 1'b1;
                ha <= REQA;
                hw <= REQW;
                hd <= REQD;
            end
            PHI1    <= (p_nxt < 3'd3);
            PHI0    <= (p_nxt >= 3'd3);
            nDEVSEL <= !(dev_hit && (p_nxt >= 3'd3));
            nIOSEL  <= !(io_hit && (p_nxt >= 3'd3));
            nIOSTRB <= !(strb_hit && (p_nxt >= 3'd3));
            DOE     <= drive;
            Dout    <= drive ? cd : 8'h00;
        end
    end

endmodule

// File: tb/tb_a2bus_host.sv
// Bench for a2bus_host: directed scenarios plus random traffic, every edge
// compared against a bus-cycle level reference model.
module tb_a2bus_host;

    localparam logic [2:0] SLOT   = 3'd7;
    localparam int         LONGEN = 1;
    localparam int         DEV_LO = 32'hC080 + 16 * SLOT;

    logic        C7M = 1'b0;
    logic        RES = 1'b1;
    logic        REQ = 1'b0;
    logic        RDY;
    logic [15:0] REQA = '0;
    logic        REQW = 1'b0;
    logic [7:0]  REQD = '0;
    logic        DONE;
    logic [7:0]  RDATA;
    logic        PHI0, PHI1;
    logic [15:0] A;
    logic        nWE;
    logic [7:0]  Dout;
    logic        DOE;
    logic [7:0]  Din = '0;
    logic        nDEVSEL, nIOSEL, nIOSTRB;

    a2bus_host #(.SLOT(SLOT), .LONGEN(LONGEN)) dut (
        .C7M(C7M), .RES(RES), .REQ(REQ), .RDY(RDY), .REQA(REQA), .REQW(REQW),
        .REQD(REQD), .DONE(DONE), .RDATA(RDATA), .PHI0(PHI0), .PHI1(PHI1),
        .A(A), .nWE(nWE), .Dout(Dout), .DOE(DOE), .Din(Din),
        .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB)
    );

    always #5 C7M = ~C7M;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // reference model: phase within bus cycle, cycle index, queue-of-one
    int          m_ph = 0;
    int          m_cyc = 0;
    bit          h_v = 0;
    logic [15:0] h_a = '0;
    bit          h_w = 0;
    logic [7:0]  h_d = '0;
    bit          c_v = 0;
    logic [15:0] c_a = '0;
    bit          c_w = 0;
    logic [7:0]  c_d = '0;
    logic [7:0]  m_rdata = '0;
    bit          m_done = 0;
    bit          acc = 0;
    int          acc_total = 0;
    int          m_done_total = 0;
    int          dut_done_total = 0;
    int          tcount = 0;
    int          last_done_t = 0;
    int          prev_done_t = 0;
    int          dev_low = 0, io_low = 0, strb_low = 0, doe_hi = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cyc_len(input int c);
        return (LONGEN != 0 && c == 64) ? 8 : 7;
    endfunction

    task automatic tick();
        logic [15:0] e_a;
        bit          sel_win;
        @(posedge C7M);
        tcount++;
        if (RES) begin
            m_ph = 0; m_cyc = 0; h_v = 0; c_v = 0; c_w = 0;
            m_rdata = '0; m_done = 0; acc = 0;
        end else begin
            acc    = REQ && !h_v;
            m_done = 0;
            if (m_ph == cyc_len(m_cyc) - 1) begin
                if (c_v) begin
                    m_done = 1;
                    m_done_total++;
                    if (!c_w) m_rdata = Din;
                end
                c_v = h_v; c_a = h_a; c_w = h_w; c_d = h_d;
                h_v = 0;
                m_ph = 0;
                m_cyc = (m_cyc + 1) % 65;
            end else begin
                m_ph++;
            end
            if (acc) begin
                acc_total++;
                h_v = 1; h_a = REQA; h_w = REQW; h_d = REQD;
            end
        end
        #1;
        e_a     = c_v ? c_a : 16'h0000;
        sel_win = c_v && m_ph >= 3;
        check("PHI1", PHI1, m_ph < 3);
        check("PHI0", PHI0, m_ph >= 3);
        check("A", A, e_a);
        check("nWE", nWE, !(c_v && c_w));
        check("nDEVSEL", nDEVSEL, !(sel_win && e_a >= DEV_LO && e_a <= DEV_LO + 15));
        check("nIOSEL", nIOSEL, !(sel_win && (e_a >> 8) == 32'hC0 + SLOT));
        check("nIOSTRB", nIOSTRB, !(sel_win && e_a >= 16'hC800 && e_a <= 16'hCFFF));
        check("DOE", DOE, c_v && c_w && m_ph >= 4);
        check("Dout", Dout, (c_v && c_w && m_ph >= 4) ? c_d : 8'h00);
        check("RDY", RDY, !h_v);
        check("DONE", DONE, m_done);
        check("RDATA", RDATA, m_rdata);
        if (DONE) begin
            dut_done_total++;
            prev_done_t = last_done_t;
            last_done_t = tcount;
        end
        if (!nDEVSEL) dev_low++;
        if (!nIOSEL) io_low++;
        if (!nIOSTRB) strb_low++;
        if (DOE) doe_hi++;
    endtask

    task automatic send(input logic [15:0] a, input logic w, input logic [7:0] d);
        REQ = 1'b1; REQA = a; REQW = w; REQD = d;
        acc = 0;
        for (int i = 0; i < 40 && !acc; i++) tick();
        REQ = 1'b0;
        check("accept_in_time", acc, 1);
    endtask

    task automatic wait_done_total(input int target);
        for (int i = 0; i < 60 && dut_done_total < target; i++) tick();
        check("done_in_time", dut_done_total, target);
    endtask

    int run, run4, run5, base_done, base_acc;

    initial begin
        // reset
        RES = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("rst_PHI1", PHI1, 1);
        check("rst_A", A, 16'h0000);
        check("rst_RDY", RDY, 1);
        RES = 1'b0;

        // idle: 65 cycles, exactly one stretched PHI0
        run = 0; run4 = 0; run5 = 0;
        for (int i = 0; i < 460; i++) begin
            tick();
            if (PHI0) run++;
            else if (run > 0) begin
                if (run == 4) run4++;
                if (run == 5) run5++;
                run = 0;
            end
        end
        check("idle_phi0_4runs", run4, 64);
        check("idle_phi0_5runs", run5, 1);
        check("idle_no_done", dut_done_total, 0);

        // read of the slot device space
        Din = 8'h5A;
        dev_low = 0;
        base_done = dut_done_total;
        send(16'hC0F3, 1'b0, 8'h00);
        wait_done_total(base_done + 1);
        check("rd_rdata", RDATA, 8'h5A);
        check("rd_devsel_len", dev_low, 4);

        // write to slot ROM
        io_low = 0; doe_hi = 0;
        base_done = dut_done_total;
        send(16'hC700, 1'b1, 8'hA5);
        wait_done_total(base_done + 1);
        check("wr_rdata_kept", RDATA, 8'h5A);
        check("wr_iosel_len", io_low, 4);
        check("wr_doe_len", doe_hi, 3);
        tick();
        check("wr_single_done", dut_done_total, base_done + 1);

        // back-to-back expansion ROM reads
        strb_low = 0;
        base_done = dut_done_total;
        Din = 8'h3C;
        send(16'hC800, 1'b0, 8'h00);
        send(16'hCFFF, 1'b0, 8'h00);
        wait_done_total(base_done + 2);
        check("b2b_done_gap", last_done_t - prev_done_t, 7);
        check("b2b_strb_len", strb_low, 8);

        // reset in the middle of a write
        base_done = dut_done_total;
        send(16'hC0F0, 1'b1, 8'hC3);
        for (int i = 0; i < 40 && !(m_ph == 4 && c_v); i++) tick();
        check("reach_p4", m_ph == 4 && c_v, 1);
        RES = 1'b1;
        tick();
        check("rst_mid_DOE", DOE, 0);
        check("rst_mid_nWE", nWE, 1);
        RES = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("rst_mid_no_done", dut_done_total, base_done);

        // REQ held while the register is full
        base_done = dut_done_total;
        base_acc  = acc_total;
        REQ = 1'b1; REQA = 16'hC0F5; REQW = 1'b0; REQD = 8'h00;
        Din = 8'h99;
        acc = 0;
        for (int i = 0; i < 40 && !acc; i++) tick();
        for (int i = 0; i < 20 && !RDY; i++) tick();
        REQ = 1'b0;
        wait_done_total(base_done + 1);
        check("held_req_once", acc_total - base_acc, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (!REQ || $urandom_range(0, 3) == 0) begin
                REQ  = ($urandom_range(0, 2) == 0);
                REQW = $urandom_range(0, 1);
                REQD = 8'($urandom);
                case ($urandom_range(0, 4))
                    0: REQA = 16'hC0F0 + 16'($urandom_range(0, 15));
                    1: REQA = 16'hC700 + 16'($urandom_range(0, 255));
                    2: REQA = 16'hC800 + 16'($urandom_range(0, 2047));
                    3: REQA = 16'hC080 + 16'($urandom_range(0, 255));
                    default: REQA = 16'($urandom);
                endcase
            end
            Din = 8'($urandom);
            RES = ($urandom_range(0, 249) == 0);
            tick();
        end
        RES = 1'b0;
        REQ = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("done_total", dut_done_total, m_done_total);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
